c_shift_ram_mc: RTL
===================

# c_shift_ram_mc

Multi-channel, runtime-programmable delay line for aligning parallel feature-map and control streams in the convolution and RPN datapaths. Delays CH lanes of WID-bit data plus one shared valid bit by a selectable 1..LEN_MAX clock-enable steps. Tracks pipeline fill so downstream logic never consumes stale taps after reset or a delay change.

## Interface
- LEN_MAX, 16: maximum delay in CE steps (>= 1)
- WID, 8: data width per channel
- CH, 4: number of parallel channels
- DLY_W, $clog2(LEN_MAX+1): width of delay select
- CLK  in  1  clock; all state updates on rising edge
- SCLR  in  1  reset; synchronous, active-high
- CE  in  1  clock enable; shift/advance only when high
- D  in  CH*WID  input data; channel c at bits [c*WID +: WID]
- D_VALID  in  1  valid tag travelling with D
- DLY  in  DLY_W  requested delay, sampled every cycle
- Q  out  CH*WID  delayed data, forced 0 when Q_VALID low
- Q_VALID  out  1  delayed valid tag AND primed
- PRIMED  out  1  high when the pipeline holds DLY fresh stages

## Operation
- Storage: per channel, LEN_MAX-stage register chain; a parallel LEN_MAX-stage valid chain vsr.
- On CE=1, SCLR=0: stage 0 <= D / D_VALID, stage i <= stage i-1 for all channels.
- Effective delay dly_q = clamp(DLY): 0 -> 1, > LEN_MAX -> LEN_MAX, else DLY. dly_q registered each cycle, independent of CE.
- Output tap: stage dly_q-1 (combinational mux from registers).
- Q_VALID = vsr[dly_q-1] & PRIMED; Q = Q_VALID ? tap data : 0.
- State machine (states EMPTY, FILL, RUN):
  - SCLR -> EMPTY, fill_cnt = 0.
  - EMPTY: first CE -> FILL with fill_cnt = 1 (or RUN directly if dly_q = 1).
  - FILL: each CE increments fill_cnt; fill_cnt reaching dly_q -> RUN.
  - RUN: holds; fill_cnt saturates at LEN_MAX.
  - Any cycle where clamp(DLY) != dly_q: next cycle fill_cnt = 0, state FILL (EMPTY if from EMPTY); overrides CE increment that cycle.
- PRIMED = (state == RUN).
- CE=0: all chains, fill_cnt and state hold; dly_q still updates and a change still resets fill.
- SCLR with CE=1 in same cycle: SCLR wins, no shift.

## Timing
- Reset values: Q = 0, Q_VALID = 0, PRIMED = 0, vsr all 0, fill_cnt = 0, dly_q = clamp(DLY) at next cycle.
- Latency: with CE continuously high, D presented in cycle t appears at Q in cycle t+dly_q.
- After SCLR release or delay change, PRIMED rises after exactly dly_q CE cycles; no Q_VALID before then.
- Decreasing delay (e.g. 8 -> 3) does not expose the older taps: refill of 3 CE cycles required.
- No combinational path from D to Q; DLY to Q is combinational via dly_q register only (one-cycle effect).

## Configuration
- C_SHIFT_RAM_CLR_DATA_EN defined: SCLR also zeroes every data stage in every channel.
- Undefined: SCLR clears only vsr, fill_cnt and state; data chains are reset-free (SRL-inferable). Observable Q identical in both builds because Q is masked by Q_VALID.

## Structure
- Package c_shift_ram_pkg: state enum (EMPTY, FILL, RUN), clamp_dly function parameterised by LEN_MAX.
- Sub-module c_shift_ram_lane: one WID-bit LEN_MAX-deep chain plus tap mux, instantiated CH times; top holds vsr, FSM, fill_cnt, dly_q and masking.

## Test plan
- Reset/fill: SCLR 1 cycle, DLY=4, CE=1, D_VALID=1, D = ramp 1,2,3... -> PRIMED and Q_VALID rise 4 cycles after release, first Q channel 0 = 1.
- CE gating: DLY=3, CE toggling 1,0,1,0... -> Q advances only on CE-high edges, latency 3 CE steps, values unchanged during CE=0.
- Delay change: running at DLY=8, switch to DLY=2 -> Q_VALID low for 2 CE cycles, then Q = D delayed by 2; no sample from stages 2..7 observed.
- Clamp: DLY=0 -> behaves as 1; DLY=31 with LEN_MAX=16 -> behaves as 16.
- Channel independence: CH=4, channel c driven with c*0x10 + t -> each Q lane returns its own stream, no cross-lane mixing; D_VALID=0 bubble reappears as Q_VALID=0, Q=0 exactly dly_q cycles later.
- SCLR mid-run with CE=1 (both macro settings): next cycle Q=0, Q_VALID=0, PRIMED=0; refill takes dly_q CE cycles.

Source files
------------

// File: rtl/c_shift_ram_pkg.sv
// Shared types and helpers for the c_shift_ram_mc multi-channel delay line.
package c_shift_ram_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StFill,
        StRun
    } state_e;

    // Map a requested delay onto the legal range 1..len_max.
    function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned len_max);
        if (dly == 0) begin
            return 1;
        end
        if (dly > len_max) begin
            return len_max;
        end
        return dly;
    endfunction

endpackage

// File: rtl/c_shift_ram_lane.sv
// One WID-bit, LEN_MAX-deep shift chain with a registered-tap output mux.
// C_SHIFT_RAM_CLR_DATA_EN: when defined, SCLR also zeroes the data stages.
module c_shift_ram_lane
    import c_shift_ram_pkg::*;
#(
    parameter int unsigned LEN_MAX = 16,
    parameter int unsigned WID     = 8,
    parameter int unsigned DLY_W   = 5
) (
    input  logic             clk_i,
    input  logic             sclr_i,
    input  logic             ce_i,
    input  logic [WID-1:0]   d_i,
    input  logic [DLY_W-1:0] tap_i,
    output logic [WID-1:0]   q_o
);

    logic [LEN_MAX-1:0][WID-1:0] sr_q;
    logic [LEN_MAX-1:0][WID-1:0] sr_d;

    always_comb begin
        sr_d[0] = d_i;
        for (int unsigned i = 1; i < LEN_MAX; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
`ifdef C_SHIFT_RAM_CLR_DATA_EN
        if (sclr_i) begin
            sr_q <= '0;
        end else if (ce_i) begin
            sr_q <= sr_d;
        end
`else
        // No reset on the data path so the chain can map onto shift-register primitives.
        if (!sclr_i && ce_i) begin
            sr_q <= sr_d;
        end
`endif
    end

    always_comb begin
        q_o = '0;
        for (int unsigned i = 0; i < LEN_MAX; i++) begin
            if (tap_i == DLY_W'(i)) begin
                q_o = sr_q[i];
            end
        end
    end

endmodule

// File: rtl/c_shift_ram_mc.sv
// Multi-channel runtime-programmable delay line with pipeline-fill tracking.
// C_SHIFT_RAM_CLR_DATA_EN: when defined, SCLR also clears every data stage.
module c_shift_ram_mc
    import c_shift_ram_pkg::*;
#(
    parameter int unsigned LEN_MAX = 16,
    parameter int unsigned WID     = 8,
    parameter int unsigned CH      = 4,
    parameter int unsigned DLY_W   = $clog2(LEN_MAX + 1)
) (
    input  logic                CLK,
    input  logic                SCLR,
    input  logic                CE,
    input  logic [CH*WID-1:0]   D,
    input  logic                D_VALID,
    input  logic [DLY_W-1:0]    DLY,
    output logic [CH*WID-1:0]   Q,
    output logic                Q_VALID,
    output logic                PRIMED
);

    state_e               state_q, state_d;
    logic [DLY_W-1:0]     cnt_q, cnt_d;
    logic [DLY_W-1:0]     dly_q;
    logic [DLY_W-1:0]     dly_clamp;
    logic                 dly_chg;
    logic [LEN_MAX-1:0]   vsr_q, vsr_d;
    logic [DLY_W-1:0]     tap_sel;
    logic                 vsr_tap;
    logic                 q_valid;
    logic [CH-1:0][WID-1:0] lane_q;

    assign dly_clamp = DLY_W'(clamp_dly(32'(DLY), LEN_MAX));
    assign dly_chg   = (dly_clamp != dly_q);
    assign tap_sel   = dly_q - DLY_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vsr_d   = vsr_q;
        if (CE) begin
            vsr_d[0] = D_VALID;
            for (int unsigned i = 1; i < LEN_MAX; i++) begin
                vsr_d[i] = vsr_q[i-1];
            end
        end
        // A delay change restarts the fill count even on a CE cycle.
        if (dly_chg) begin
            cnt_d   = '0;
            state_d = (state_q == StEmpty) ? StEmpty : StFill;
        end else if (CE) begin
            case (state_q)
                StEmpty: begin
                    cnt_d   = DLY_W'(1);
                    state_d = (dly_q == DLY_W'(1)) ? StRun : StFill;
                end
                StFill: begin
                    cnt_d = cnt_q + DLY_W'(1);
                    if ((cnt_q + DLY_W'(1)) >= dly_q) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (cnt_q < DLY_W'(LEN_MAX)) begin
                        cnt_d = cnt_q + DLY_W'(1);
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        dly_q <= dly_clamp;
        if (SCLR) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
            vsr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vsr_q   <= vsr_d;
        end
    end

    always_comb begin
        vsr_tap = 1'b0;
        for (int unsigned i = 0; i < LEN_MAX; i++) begin
            if (tap_sel == DLY_W'(i)) begin
                vsr_tap = vsr_q[i];
            end
        end
    end

    assign PRIMED  = (state_q == StRun);
    assign q_valid = vsr_tap & PRIMED;
    assign Q_VALID = q_valid;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        c_shift_ram_lane #(
            .LEN_MAX (LEN_MAX),
            .WID     (WID),
            .DLY_W   (DLY_W)
        ) u_lane (
            .clk_i  (CLK),
            .sclr_i (SCLR),
            .ce_i   (CE),
            .d_i    (D[c*WID +: WID]),
            .tap_i  (tap_sel),
            .q_o    (lane_q[c])
        );
    end

    always_comb begin
        Q = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            Q[c*WID +: WID] = q_valid ? lane_q[c] : '0;
        end
    end

endmodule
